// File: rtl/bcd_scan_display.sv
// Six-digit BCD display scanner: snapshots x5..x0 once per frame, strobes one digit at a time.
// Registered outputs (1-cycle latency), leading-zero blanking and an expiry blink at 00:00:00.
module bcd_scan_display #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] x5,
  input  logic [3:0] x4,
  input  logic [3:0] x3,
  input  logic [3:0] x2,
  input  logic [3:0] x1,
  input  logic [3:0] x0,
  input  logic       lzb,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BF_CNT   = CW'(BLINK_FRAMES);

  logic [PW-1:0]     pre_q, pre_d;
  logic [2:0]        idx_q, idx_d;
  logic [5:0][3:0]   shadow_q, shadow_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [6:0]        seg_q, seg_d;
  logic [5:0]        an_q, an_d;
  logic              dp_q, dp_d;
  logic              fd_q, fd_d;

  logic              frame_start;
  logic              zero;
  logic              blank;
  logic              run_zero;
  logic [5:0]        lead_zero;
  logic [3:0]        digit;
  logic [6:0]        code;

  always_comb begin
    frame_start = (idx_q == 3'd5) && (pre_q == '0);

    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      idx_d = (idx_q == 3'd0) ? 3'd5 : idx_q - 3'd1;
    end

    // Decode from the incoming snapshot so the first strobe of a frame is already current.
    shadow_d = frame_start ? {x5, x4, x3, x2, x1, x0} : shadow_q;

    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    zero    = (shadow_d == '0) && blink_en;
    if (frame_start) begin
      if (!zero) begin
        bcnt_d  = '0;
        phase_d = 1'b1;
      end else if (bcnt_q == BF_CNT) begin
        bcnt_d  = CW'(1);
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + CW'(1);
      end
    end

    run_zero = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      run_zero     = run_zero && (shadow_d[i] == 4'd0);
      lead_zero[i] = run_zero;
    end

    digit = 4'd0;
    case (idx_q)
      3'd0:    digit = shadow_d[0];
      3'd1:    digit = shadow_d[1];
      3'd2:    digit = shadow_d[2];
      3'd3:    digit = shadow_d[3];
      3'd4:    digit = shadow_d[4];
      default: digit = shadow_d[5];
    endcase

    case (digit)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h3F;
    endcase

    blank = lzb && (idx_q >= 3'd2) && (idx_q <= 3'd5) && lead_zero[idx_q];

    seg_d = (!phase_d || blank) ? 7'h7F : code;
    an_d  = !phase_d ? 6'h3F : ~(6'b1 << idx_q);
    dp_d  = blank ? 1'b1 : !((idx_q == 3'd4) || (idx_q == 3'd2));
    fd_d  = (idx_q == 3'd0) && (pre_q == PRE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      idx_q    <= 3'd5;
      shadow_q <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
      seg_q    <= 7'h7F;
      an_q     <= 6'h3F;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: directed and random digit streams against a frame-level model.
module tb_bcd_scan_display;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] xin [6];
  logic       lzb = 1'b0;
  logic       blink_en = 1'b0;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;
  logic       frame_done;

  int total = 0;
  int bad = 0;

  // Model state: steps since reset release, frame snapshot, consecutive all-zero frames.
  int         s;
  logic [3:0] snap [6];
  int         zrun;
  bit         vis;
  logic [6:0] seg_tab [16];

  bcd_scan_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst),
    .x5(xin[5]), .x4(xin[4]), .x3(xin[3]), .x2(xin[2]), .x1(xin[1]), .x0(xin[0]),
    .lzb(lzb), .blink_en(blink_en),
    .seg(seg), .an(an), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_reset_vals(input string tag);
    total++;
    assert (seg === 7'h7F) else begin bad++; $error("FAIL %s_seg got=%h exp=7f", tag, seg); end
    total++;
    assert (an === 6'h3F) else begin bad++; $error("FAIL %s_an got=%h exp=3f", tag, an); end
    total++;
    assert (dp === 1'b1) else begin bad++; $error("FAIL %s_dp got=%b exp=1", tag, dp); end
    total++;
    assert (frame_done === 1'b0) else begin bad++; $error("FAIL %s_fd got=%b exp=0", tag, frame_done); end
  endtask

  task automatic set_digits(input logic [23:0] v);
    for (int i = 0; i < 6; i++) xin[i] = v[i*4 +: 4];
  endtask

  task automatic tick();
    int         idx;
    int         pre;
    bit         allz;
    bit         lz;
    logic [6:0] seg_e;
    logic [5:0] an_e;
    logic       dp_e;
    logic       fd_e;
    if (s % FRAME == 0) begin
      allz = 1'b1;
      for (int i = 0; i < 6; i++) begin
        snap[i] = xin[i];
        if (xin[i] != 4'd0) allz = 1'b0;
      end
      if (allz && blink_en) begin
        zrun++;
        vis = (((zrun - 1) / BF) % 2) == 0;
      end else begin
        zrun = 0;
        vis  = 1'b1;
      end
    end
    idx = 5 - ((s / SD) % 6);
    pre = s % SD;
    lz = 1'b0;
    if (lzb && idx >= 2) begin
      lz = 1'b1;
      for (int j = idx; j <= 5; j++) if (snap[j] != 4'd0) lz = 1'b0;
    end
    seg_e = (!vis || lz) ? 7'h7F : seg_tab[snap[idx]];
    an_e  = !vis ? 6'h3F : ~(6'(1) << idx);
    dp_e  = lz ? 1'b1 : !(idx == 4 || idx == 2);
    fd_e  = (idx == 0) && (pre == SD - 1);
    @(posedge clk);
    #1;
    total++;
    assert (seg === seg_e) else begin bad++; $error("FAIL seg s=%0d got=%h exp=%h", s, seg, seg_e); end
    total++;
    assert (an === an_e) else begin bad++; $error("FAIL an s=%0d got=%b exp=%b", s, an, an_e); end
    total++;
    assert (dp === dp_e) else begin bad++; $error("FAIL dp s=%0d got=%b exp=%b", s, dp, dp_e); end
    total++;
    assert (frame_done === fd_e) else begin bad++; $error("FAIL frame_done s=%0d got=%b exp=%b", s, frame_done, fd_e); end
    s++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    set_digits(24'h123456);
    s = 0;
    zrun = 0;
    vis = 1'b1;
    for (int i = 0; i < 6; i++) snap[i] = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("post_release");

    // 12:34:56 steady, two frames
    ticks(2 * FRAME);

    // Mid-frame change only appears from the next frame
    ticks(10);
    set_digits(24'h000007);
    ticks(FRAME - 10 + FRAME);

    // Leading-zero blanking
    lzb = 1'b1;
    set_digits(24'h000509);
    ticks(2 * FRAME);
    set_digits(24'h000000);
    ticks(FRAME);

    // Expiry blink, then recovery to a steady display
    lzb = 1'b0;
    blink_en = 1'b1;
    ticks(9 * FRAME);
    ticks(7);
    set_digits(24'h000001);
    ticks(FRAME - 7 + 2 * FRAME);

    // Non-BCD digits show a dash
    set_digits(24'h1AC9F2);
    ticks(FRAME);

    // Random digits, controls and change times
    for (int f = 0; f < 30; f++) begin
      logic [23:0] v;
      for (int i = 0; i < 6; i++)
        v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = 24'h0;
      set_digits(v);
      lzb = 1'($urandom_range(0, 1));
      blink_en = 1'($urandom_range(0, 1));
      ticks($urandom_range(1, 2 * FRAME));
    end

    // Asynchronous reset in the middle of a scan
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    s = 0;
    zrun = 0;
    vis = 1'b1;
    lzb = 1'b0;
    blink_en = 1'b0;
    set_digits(24'h235959);
    ticks(3 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
